alu_seq_ctrl: RTL

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

---
 rtl/alu_seq_ctrl.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/alu_seq_ctrl.sv
// Sequential ALU controller: single-cycle add/sub/and/or/nor/slt with an
// optional WIDTH-cycle shift-add multiplier.
// Build macro ALU_SEQ_MUL_EN enables the multiplier (state MUL, funct 1000);
// without it, funct 1000 decodes as illegal.
// WIDTH is intended for 8..64.
module alu_seq_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       aluop,
  input  logic [3:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

`ifdef ALU_SEQ_MUL_EN
  typedef enum logic [1:0] {StIdle, StExec, StMul} state_e;
  localparam int unsigned CntW = $clog2(WIDTH) + 1;
`else
  typedef enum logic [1:0] {StIdle, StExec} state_e;
`endif

  typedef enum logic [2:0] {OpAdd, OpSub, OpAnd, OpOr, OpNor, OpSlt, OpMul, OpIll} op_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             illegal_q, illegal_d;
  logic             done_q, done_d;

  op_e              op;
  logic [WIDTH-1:0] alu_res;

`ifdef ALU_SEQ_MUL_EN
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_step;
`endif

  // Decode aluop/funct into an internal operation class.
  always_comb begin
    op = OpIll;
    case (aluop)
      2'b00: op = OpAdd;
      2'b01: op = OpSub;
      2'b10: begin
        case (funct)
          4'b0000: op = OpAdd;
          4'b0010: op = OpSub;
          4'b0100: op = OpAnd;
          4'b0101: op = OpOr;
          4'b0111: op = OpNor;
          4'b1010: op = OpSlt;
`ifdef ALU_SEQ_MUL_EN
          4'b1000: op = OpMul;
`endif
          default: op = OpIll;
        endcase
      end
      default: op = OpIll;
    endcase
  end

  // Single-cycle datapath, evaluated on the request inputs at acceptance.
  always_comb begin
    alu_res = '0;
    case (op)
      OpAdd:   alu_res = a + b;
      OpSub:   alu_res = a - b;
      OpAnd:   alu_res = a & b;
      OpOr:    alu_res = a | b;
      OpNor:   alu_res = ~(a | b);
      OpSlt:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: alu_res = '0;
    endcase
  end

  // Next-state logic: FSM, result registers and multiplier iteration.
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    done_d    = 1'b0;
`ifdef ALU_SEQ_MUL_EN
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    acc_step  = acc_q + (mplier_q[0] ? mcand_q : '0);
`endif
    case (state_q)
      StIdle: begin
        if (start) begin
`ifdef ALU_SEQ_MUL_EN
          if (op == OpMul) begin
            // First partial product folded into acceptance so the last
            // step lands exactly WIDTH cycles later.
            state_d  = StMul;
            acc_d    = b[0] ? a : '0;
            mcand_d  = a << 1;
            mplier_d = b >> 1;
            cnt_d    = CntW'(1);
          end else
`endif
          begin
            // Result registered at acceptance so it is valid with done.
            state_d   = StExec;
            result_d  = alu_res;
            zero_d    = (alu_res == '0);
            illegal_d = (op == OpIll);
            done_d    = 1'b1;
          end
        end
      end
      StExec: state_d = StIdle;
`ifdef ALU_SEQ_MUL_EN
      StMul: begin
        if (done_q) begin
          state_d = StIdle;
        end else begin
          acc_d    = acc_step;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + CntW'(1);
          if (cnt_q == CntW'(WIDTH - 1)) begin
            result_d  = acc_step;
            zero_d    = (acc_step == '0);
            illegal_d = 1'b0;
            done_d    = 1'b1;
          end
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      result_q  <= '0;
      zero_q    <= 1'b1;
      illegal_q <= 1'b0;
      done_q    <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
      done_q    <= done_d;
`ifdef ALU_SEQ_MUL_EN
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign ready   = (state_q == StIdle);
  assign done    = done_q;
  assign result  = result_q;
  assign zero    = zero_q;
  assign illegal = illegal_q;

endmodule
